// File: rtl/piso_serializer_pkg.sv
// serial_pkg: shared state encoding and counter sizing for the serializer
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial output bundle
interface piso_serializer_if #(parameter int W = 8);
  logic [W-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;
  modport master (output din, load_valid, input load_ready, sout, sout_valid, busy, done);
  modport slave  (input din, load_valid, output load_ready, sout, sout_valid, busy, done);
endinterface

// File: rtl/piso_serializer_bit_timer.sv
// bit_timer: prescaler that ticks on the final clock of each bit period
module bit_timer
  import serial_pkg::*;
#(parameter int N = 1)
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic tick
);
  localparam int CW = cnt_width(N);
  logic [CW-1:0] cnt;
  assign tick = run && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (start || tick) cnt <= CW'(N - 1);
    else if (run) cnt <= cnt - 1'b1;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: loads a word via valid/ready and shifts it out on sout
module piso_serializer
  import serial_pkg::*;
#(
  parameter int W            = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
)
(
  input logic              clk,
  input logic              rst_n,
  piso_serializer_if.slave bus
);
  localparam int BW = cnt_width(W);
  state_t        state, nstate;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bcnt;
  logic          tick, last, ready, hs, shifting;
  bit_timer #(.N(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (hs),
    .run   (shifting),
    .tick  (tick)
  );
  // ready depends only on state/counters so the source never sees a loop
  always_comb begin
    shifting       = state == SHIFT;
    last           = tick && bcnt == '0;
    ready          = !shifting || last;
    hs             = bus.load_valid && ready;
    nstate         = hs ? SHIFT : last ? IDLE : state;
    bus.load_ready = ready;
    bus.sout_valid = shifting;
    bus.busy       = shifting;
    bus.done       = last;
    bus.sout       = shifting && (MSB_FIRST ? shreg[W-1] : shreg[0]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (hs) begin
      shreg <= bus.din;
      bcnt  <= BW'(W - 1);
    end else if (tick) begin
      shreg <= MSB_FIRST ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};
      bcnt  <= (bcnt == '0) ? '0 : bcnt - 1'b1;
    end
endmodule
